pipe_scroller: RTL and testbench
================================

// Module: pipe_scroller
// PURPOSE
//  Game-logic stage that produces the pipe positions consumed by the display manager.
//  Holds two pipes and scrolls them left one step per game tick; a pipe that leaves the screen wraps to the right with a new random gap height.
//  Counts pipes that pass the bird column and freezes on a halt (collision) request.
// PARAMETERS
//  SCREEN_W      640      visible width in pixels; initial pipe1_x
//  PIPE_W        40       pipe width in pixels
//  PIPE_SPACING  320      x distance between pipe1 and pipe2; wrap period is 2*PIPE_SPACING
//  STEP          1        pixels moved per tick (1..PIPE_W)
//  TICK_DIV      500000   clk cycles per game tick (>=2)
//  BIRD_X        100      bird column used for pass detection
//  GAP_MIN       80       smallest gap y
//  GAP_MAX       380      largest gap y; RANGE = GAP_MAX-GAP_MIN+1 must be 256..511
//  LFSR_SEED     16'hACE1 non-zero LFSR reset value
// PORTS
//  clk      in   1   system clock
//  reset    in   1   asynchronous, active-low reset
//  start    in   1   1-cycle pulse: (re)start scrolling
//  halt     in   1   level/pulse: freeze the game (collision)
//  pipe1_x  out  11  pipe1 left edge x
//  pipe1_y  out  11  pipe1 gap y
//  pipe2_x  out  11  pipe2 left edge x
//  pipe2_y  out  11  pipe2 gap y
//  running  out  1   1 while in RUN
//  passed   out  1   1-cycle pulse when a pipe clears BIRD_X
//  score    out  10  pipes passed since last start, saturates at 1023
// BEHAVIOUR
//  Reset (reset==0, async, no clock edge needed): state=IDLE; pipe1_x=SCREEN_W; pipe2_x=SCREEN_W+PIPE_SPACING;
//   pipe1_y=pipe2_y=GAP_MID=(GAP_MIN+GAP_MAX)/2; tick counter=0; running=0; passed=0; score=0; lfsr=LFSR_SEED.
//  States: IDLE, RUN, FROZEN. All outputs registered.
//   IDLE  : start -> RUN (halt ignored). Positions held at reset values.
//   RUN   : halt -> FROZEN (halt wins over start and over a coincident tick: no move that cycle).
//   FROZEN: start -> RUN with positions, y values, tick counter and score re-initialised to reset values (lfsr NOT reset).
//  Tick: counter runs 0..TICK_DIV-1 only in RUN, cleared on entry to RUN; move occurs on the cycle counter==TICK_DIV-1,
//   so first move is visible TICK_DIV cycles after start is sampled.
//  Move (per pipe, independent): if x >= STEP then x <= x-STEP;
//   else wrap: x <= x + 2*PIPE_SPACING - STEP and y <= new gap. Spacing between pipes is preserved exactly.
//  Gap: r = 9-bit LFSR slice; y = GAP_MIN + (r >= RANGE ? r-RANGE : r). pipe1 uses lfsr[8:0], pipe2 uses lfsr[15:7],
//   so a simultaneous wrap gives distinct draws. Result always within [GAP_MIN, GAP_MAX].
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every clk in every state (start timing randomises gaps).
//  Pass: on a move where old x+PIPE_W > BIRD_X and new x+PIPE_W <= BIRD_X (no wrap), passed=1 for that cycle and score+1.
//   Both pipes passing on one tick: single pulse, score+2 (saturating). Wrap never counts as a pass.
//  Width rules: all coordinate math in 12 bits, result truncated to 11; parameters must satisfy SCREEN_W+PIPE_SPACING<=2047
//   and 2*PIPE_SPACING<=2047 (checked by an elaboration-time assertion).
// STRUCTURE
//  Shared package flappy_pkg: coord_t (logic [10:0]), SCREEN_W/SCREEN_H constants, game_state_t enum {IDLE, RUN, FROZEN}.
//  One sub-module: lfsr16 (clk, reset, seed param, q[15:0]); gap mapping and wrap logic inline, one instance per pipe via a function.
// TESTING  (TICK_DIV=4, defaults otherwise)
//  1 reset low then high -> pipe1_x=640, pipe2_x=960, both y=230, score=0, running=0, passed=0.
//  2 start pulse -> running=1; pipe1_x 639 / pipe2_x 959 exactly 4 cycles later, 638/958 after 8.
//  3 run until pipe1_x=0, next tick -> pipe1_x=639, pipe1_y in [80,380], pipe2_x unchanged spacing (pipe2_x-pipe1_x mod 640 == 320).
//  4 pipe1_x steps 61->60 -> passed=1 for one cycle, score 0->1; no pulse on the wrap tick.
//  5 halt during RUN for 100 cycles -> all x/y frozen, running=0; start -> positions back to 640/960, score=0, scrolling resumes.
//  6 assert reset mid-run between clock edges -> outputs take reset values immediately; start+halt same cycle in RUN -> FROZEN.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared game types and screen constants for the flappy game-logic stages.
package flappy_pkg;

    typedef logic [10:0] coord_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } game_state_t;

    // Result of advancing one pipe by one tick.
    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   pass;
    } pipe_step_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1; advances every clock.
// One cycle latency from reset release to the first new value; no flow control.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign q = r_lfsr;

endmodule

// File: rtl/pipe_scroller.sv
// Scrolls two pipes left once per game tick, wrapping them with fresh gap heights.
// Outputs registered: a move is visible TICK_DIV cycles after start; halt freezes immediately.
module pipe_scroller #(
    parameter int          SCREEN_W     = flappy_pkg::SCREEN_W,
    parameter int          PIPE_W       = 40,
    parameter int          PIPE_SPACING = 320,
    parameter int          STEP         = 1,
    parameter int          TICK_DIV     = 500000,
    parameter int          BIRD_X       = 100,
    parameter int          GAP_MIN      = 80,
    parameter int          GAP_MAX      = 380,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    output logic [10:0] pipe1_x,
    output logic [10:0] pipe1_y,
    output logic [10:0] pipe2_x,
    output logic [10:0] pipe2_y,
    output logic        running,
    output logic        passed,
    output logic [9:0]  score
);

    import flappy_pkg::*;

    localparam int GAP_MID = (GAP_MIN + GAP_MAX) / 2;
    localparam int RANGE   = GAP_MAX - GAP_MIN + 1;
    localparam int CNT_W   = $clog2(TICK_DIV);

    localparam logic [11:0]      L_STEP    = 12'(STEP);
    localparam logic [11:0]      L_WRAP    = 12'(2 * PIPE_SPACING - STEP);
    localparam logic [11:0]      L_PIPE_W  = 12'(PIPE_W);
    localparam logic [11:0]      L_BIRD_X  = 12'(BIRD_X);
    localparam logic [11:0]      L_GAP_MIN = 12'(GAP_MIN);
    localparam logic [11:0]      L_RANGE   = 12'(RANGE);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam coord_t           X1_INIT   = coord_t'(SCREEN_W);
    localparam coord_t           X2_INIT   = coord_t'(SCREEN_W + PIPE_SPACING);
    localparam coord_t           Y_INIT    = coord_t'(GAP_MID);

    if ((SCREEN_W + PIPE_SPACING > 2047) || (2 * PIPE_SPACING > 2047)) begin : g_coord_chk
        $error("pipe_scroller: coordinate parameters do not fit in 11 bits");
    end
    if ((RANGE < 256) || (RANGE > 511) || (STEP < 1) || (STEP > PIPE_W) || (TICK_DIV < 2)) begin : g_param_chk
        $error("pipe_scroller: gap range, STEP or TICK_DIV out of bounds");
    end

    // A 9-bit draw spans 0..511 and RANGE >= 256, so one subtraction folds it into range.
    function automatic coord_t gap_map(input logic [8:0] r);
        logic [11:0] w_r;
        logic [11:0] w_y;
        w_r = {3'b000, r};
        if (w_r >= L_RANGE) begin
            w_r = w_r - L_RANGE;
        end
        w_y = L_GAP_MIN + w_r;
        return w_y[10:0];
    endfunction

    function automatic pipe_step_t step_pipe(input coord_t x, input coord_t y, input logic [8:0] r);
        pipe_step_t  w_res;
        logic [11:0] w_old;
        logic [11:0] w_new;
        w_old = {1'b0, x};
        if (w_old >= L_STEP) begin
            w_new      = w_old - L_STEP;
            w_res.x    = w_new[10:0];
            w_res.y    = y;
            w_res.pass = ((w_old + L_PIPE_W) > L_BIRD_X) && ((w_new + L_PIPE_W) <= L_BIRD_X);
        end else begin
            w_new      = w_old + L_WRAP;
            w_res.x    = w_new[10:0];
            w_res.y    = gap_map(r);
            w_res.pass = 1'b0;
        end
        return w_res;
    endfunction

    game_state_t      r_state;
    game_state_t      w_next_state;
    logic             w_restart;
    logic             w_move;
    logic             w_count;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      w_lfsr;
    coord_t           r_pipe1_x;
    coord_t           r_pipe1_y;
    coord_t           r_pipe2_x;
    coord_t           r_pipe2_y;
    logic             r_running;
    logic             r_passed;
    logic [9:0]       r_score;
    pipe_step_t       w_step1;
    pipe_step_t       w_step2;
    logic [10:0]      w_score_sum;
    logic [9:0]       w_score_next;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_lfsr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Halt outranks both start and a due tick while running.
    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_move       = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                    w_restart    = 1'b1;
                end
            end
            RUN: begin
                if (halt) begin
                    w_next_state = FROZEN;
                end else if (r_cnt == TICK_LAST) begin
                    w_move = 1'b1;
                end else begin
                    w_count = 1'b1;
                end
            end
            FROZEN: begin
                if (start) begin
                    w_next_state = RUN;
                    w_restart    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Pipe2 draws from the upper slice so a simultaneous wrap gets a different gap.
    assign w_step1      = step_pipe(r_pipe1_x, r_pipe1_y, w_lfsr[8:0]);
    assign w_step2      = step_pipe(r_pipe2_x, r_pipe2_y, w_lfsr[15:7]);
    assign w_score_sum  = {1'b0, r_score} + 11'(w_step1.pass) + 11'(w_step2.pass);
    assign w_score_next = (w_score_sum > 11'd1023) ? 10'd1023 : w_score_sum[9:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_pipe1_x <= X1_INIT;
            r_pipe1_y <= Y_INIT;
            r_pipe2_x <= X2_INIT;
            r_pipe2_y <= Y_INIT;
            r_running <= 1'b0;
            r_passed  <= 1'b0;
            r_score   <= '0;
        end else begin
            r_running <= (w_next_state == RUN);
            r_passed  <= 1'b0;
            if (w_restart) begin
                r_cnt     <= '0;
                r_pipe1_x <= X1_INIT;
                r_pipe1_y <= Y_INIT;
                r_pipe2_x <= X2_INIT;
                r_pipe2_y <= Y_INIT;
                r_score   <= '0;
            end else if (w_move) begin
                r_cnt     <= '0;
                r_pipe1_x <= w_step1.x;
                r_pipe1_y <= w_step1.y;
                r_pipe2_x <= w_step2.x;
                r_pipe2_y <= w_step2.y;
                r_passed  <= w_step1.pass | w_step2.pass;
                r_score   <= w_score_next;
            end else if (w_count) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pipe1_x = r_pipe1_x;
    assign pipe1_y = r_pipe1_y;
    assign pipe2_x = r_pipe2_x;
    assign pipe2_y = r_pipe2_y;
    assign running = r_running;
    assign passed  = r_passed;
    assign score   = r_score;

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: game-level reference model compared every cycle, plus directed literal checks.
module tb_pipe_scroller;

    localparam int TD       = 4;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_FROZEN = 2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt  = 1'b0;
    logic [10:0] pipe1_x, pipe1_y, pipe2_x, pipe2_y;
    logic        running, passed;
    logic [9:0]  score;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    int          m_state, m_phase, m_x1, m_x2, m_y1, m_y2, m_score, m_pass, m_run;
    logic [15:0] m_lfsr;

    pipe_scroller #(
        .TICK_DIV (TD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .halt    (halt),
        .pipe1_x (pipe1_x),
        .pipe1_y (pipe1_y),
        .pipe2_x (pipe2_x),
        .pipe2_y (pipe2_y),
        .running (running),
        .passed  (passed),
        .score   (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: game rules in plain integer arithmetic.
    function automatic int gap_of(input int r);
        return 80 + (r % 301);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_phase = 0; m_score = 0; m_pass = 0; m_run = 0;
        m_x1 = 640; m_x2 = 960; m_y1 = 230; m_y2 = 230;
        m_lfsr = 16'hACE1;
    endtask

    task automatic enter_run();
        m_state = M_RUN; m_phase = 0; m_score = 0;
        m_x1 = 640; m_x2 = 960; m_y1 = 230; m_y2 = 230;
    endtask

    task automatic move_pipe(inout int x, inout int y, input int r, inout int npass);
        if (x >= 1) begin
            if ((x + 40 > 100) && (x - 1 + 40 <= 100)) npass++;
            x = x - 1;
        end else begin
            x = x + 640 - 1;
            y = gap_of(r);
        end
    endtask

    task automatic model_step();
        logic [15:0] lf;
        int np;
        lf     = m_lfsr;
        m_lfsr = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
        m_pass = 0;
        case (m_state)
            M_RUN: begin
                if (halt) begin
                    m_state = M_FROZEN;
                end else begin
                    m_phase++;
                    if (m_phase % TD == 0) begin
                        np = 0;
                        move_pipe(m_x1, m_y1, int'(lf[8:0]), np);
                        move_pipe(m_x2, m_y2, int'(lf[15:7]), np);
                        m_pass  = (np > 0) ? 1 : 0;
                        m_score = (m_score + np > 1023) ? 1023 : m_score + np;
                    end
                end
            end
            default: if (start) enter_run();
        endcase
        m_run = (m_state == M_RUN) ? 1 : 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("cyc_pipe1_x", pipe1_x, m_x1);
                chk("cyc_pipe1_y", pipe1_y, m_y1);
                chk("cyc_pipe2_x", pipe2_x, m_x2);
                chk("cyc_pipe2_y", pipe2_y, m_y2);
                chk("cyc_running", running, m_run);
                chk("cyc_passed",  passed,  m_pass);
                chk("cyc_score",   score,   m_score);
            end
        end
    end

    task automatic wait_x(input int which, input int val, output bit found);
        found = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (((which == 1) ? int'(pipe1_x) : int'(pipe2_x)) == val) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_p1x"}, pipe1_x, 640);
        chk({tag, "_p2x"}, pipe2_x, 960);
        chk({tag, "_p1y"}, pipe1_y, 230);
        chk({tag, "_p2y"}, pipe2_y, 230);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_passed"}, passed, 0);
    endtask

    initial begin
        bit found;
        int ex1, ex2, ey1, ey2;

        repeat (3) @(negedge clk);
        reset    = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst");

        // start: first move exactly TD cycles after start is sampled
        pulse_start();
        chk("start_running", running, 1);
        repeat (TD - 1) @(negedge clk);
        chk("pre_tick_p1x", pipe1_x, 640);
        @(negedge clk);
        chk("tick1_p1x", pipe1_x, 639);
        chk("tick1_p2x", pipe2_x, 959);
        repeat (TD) @(negedge clk);
        chk("tick2_p1x", pipe1_x, 638);
        chk("tick2_p2x", pipe2_x, 958);

        // pipe1 crosses the bird column on 61 -> 60
        wait_x(1, 61, found);
        chk("find_p1x_61", found, 1);
        chk("score_before_pass", score, 0);
        wait_x(1, 60, found);
        chk("find_p1x_60", found, 1);
        chk("pass_pulse", passed, 1);
        chk("score_after_pass", score, 1);
        @(negedge clk);
        chk("pass_pulse_end", passed, 0);

        // pipe1 wraps from 0 to 639
        wait_x(1, 0, found);
        chk("find_p1x_0", found, 1);
        found = 1'b0;
        for (int i = 0; i < 2 * TD; i++) begin
            @(negedge clk);
            if (pipe1_x != 11'd0) begin
                found = 1'b1;
                break;
            end
        end
        chk("wrap_seen", found, 1);
        chk("wrap_p1x", pipe1_x, 639);
        chk("wrap_p2x", pipe2_x, 319);
        chk("wrap_p1y_range", (pipe1_y >= 11'd80) && (pipe1_y <= 11'd380), 1);
        chk("wrap_spacing", (int'(pipe2_x) - int'(pipe1_x) + 640) % 640, 320);
        chk("wrap_no_pass", passed, 0);
        chk("wrap_score", score, 1);

        // pipe2 crosses the bird column later
        wait_x(2, 60, found);
        chk("find_p2x_60", found, 1);
        chk("p2_pass_pulse", passed, 1);
        chk("p2_score", score, 2);

        // halt on a cycle where a tick is due: no move, held for 100 cycles
        found = 1'b0;
        for (int i = 0; i < 2 * TD; i++) begin
            if (m_state == M_RUN && (m_phase % TD) == TD - 1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("halt_align", found, 1);
        ex1 = m_x1; ex2 = m_x2; ey1 = m_y1; ey2 = m_y2;
        halt = 1'b1;
        repeat (100) @(negedge clk);
        halt = 1'b0;
        chk("frz_p1x", pipe1_x, ex1);
        chk("frz_p2x", pipe2_x, ex2);
        chk("frz_p1y", pipe1_y, ey1);
        chk("frz_p2y", pipe2_y, ey2);
        chk("frz_running", running, 0);
        chk("frz_score", score, 2);

        // restart from FROZEN re-initialises positions and score
        pulse_start();
        chk("restart_p1x", pipe1_x, 640);
        chk("restart_p2x", pipe2_x, 960);
        chk("restart_score", score, 0);
        chk("restart_running", running, 1);
        repeat (TD) @(negedge clk);
        chk("restart_tick_p1x", pipe1_x, 639);

        // asynchronous reset between clock edges
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b1;

        // start and halt together while running: halt wins
        pulse_start();
        repeat (6) @(negedge clk);
        start = 1'b1;
        halt  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        halt  = 1'b0;
        chk("sh_running", running, 0);
        chk("sh_p1x", pipe1_x, 639);
        repeat (5) @(negedge clk);
        chk("sh_hold_p1x", pipe1_x, 639);
        pulse_start();
        chk("sh_restart_running", running, 1);
        chk("sh_restart_p1x", pipe1_x, 640);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
